// File: rtl/instr_cache_if.sv
// Instruction-memory read bus between the cache (master) and the memory (slave).
interface instr_cache_if;
  logic [31:0] mem_addr;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic [31:0] mem_data;
  logic        mem_hold;

  modport master (output mem_addr, mem_ce_n, mem_oe_n, input mem_data, mem_hold);
  modport slave  (input mem_addr, mem_ce_n, mem_oe_n, output mem_data, mem_hold);
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with zero-latency hits and in-order line fill.
module instr_cache #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         i_address,
  output logic [31:0]         instruction,
  output logic                hold,
  input  logic                flush,
  instr_cache_if.master       mem,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic {RUN, FILL} state_e;

  state_e                         state_q, state_d;
  logic [NUM_LINES-1:0]           valid_q, valid_d;
  logic [OFF_W-1:0]               cnt_q, cnt_d;
  logic [31:0]                    hit_q, hit_d, miss_q, miss_d;
  logic [TAG_W-1:0]               fill_tag_q, fill_tag_d;
  logic [IDX_W-1:0]               fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]               tag_mem  [NUM_LINES];
  logic [31:0]                    data_mem [NUM_LINES*WORDS_PER_LINE];
  logic                           wr_data_en, wr_tag_en, hit;

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [OFF_W-1:0] addr_off;
  logic             unused_byte_bits;

  assign addr_tag         = i_address[31 -: TAG_W];
  assign addr_idx         = i_address[2+OFF_W +: IDX_W];
  assign addr_off         = i_address[2 +: OFF_W];
  assign unused_byte_bits = ^i_address[1:0];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign hit = (state_q == RUN) && valid_q[addr_idx] && (tag_mem[addr_idx] == addr_tag);

  // Reset and flush both force a stall so no stale word is ever presented.
  assign hold        = reset | flush | ~hit;
  assign instruction = hold ? 32'd0 : data_mem[{addr_idx, addr_off}];
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;

  assign mem.mem_ce_n = (state_q != FILL);
  assign mem.mem_oe_n = (state_q != FILL);
  assign mem.mem_addr = (state_q == FILL) ? {fill_tag_q, fill_idx_q, cnt_q, 2'b00} : 32'd0;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    wr_data_en = 1'b0;
    wr_tag_en  = 1'b0;
    case (state_q)
      RUN: begin
        if (flush) begin
          valid_d = '0;
        end else if (hit) begin
          hit_d = sat_inc(hit_q);
        end else begin
          // Invalidate the victim now so a partially filled line can never hit.
          fill_tag_d        = addr_tag;
          fill_idx_d        = addr_idx;
          cnt_d             = '0;
          valid_d[addr_idx] = 1'b0;
          miss_d            = sat_inc(miss_q);
          state_d           = FILL;
        end
      end
      FILL: begin
        if (flush) begin
          valid_d = '0;
          state_d = RUN;
        end else if (!mem.mem_hold) begin
          wr_data_en = 1'b1;
          cnt_d      = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_WORD) begin
            wr_tag_en           = 1'b1;
            valid_d[fill_idx_q] = 1'b1;
            state_d             = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      valid_q <= '0;
      cnt_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Line address and storage arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clock) begin
    fill_tag_q <= fill_tag_d;
    fill_idx_q <= fill_idx_d;
    if (wr_data_en) data_mem[{fill_idx_q, cnt_q}] <= mem.mem_data;
    if (wr_tag_en)  tag_mem[fill_idx_q]           <= fill_tag_q;
  end
endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: vector table for cold miss and locality, sequences for fill corners.
module tb_instr_cache;
  logic        clock = 1'b0;
  logic        reset, flush;
  logic [31:0] i_address, instruction, hit_count, miss_count;
  logic        hold;
  logic        slow = 1'b0;
  int          st = 0;
  int          errors = 0, checks = 0;

  instr_cache_if bus ();

  instr_cache dut (
    .clock       (clock),
    .reset       (reset),
    .i_address   (i_address),
    .instruction (instruction),
    .hold        (hold),
    .flush       (flush),
    .mem         (bus.master),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
  endfunction

  // Garbage on the bus while stalled exposes any capture during mem_hold=1.
  assign bus.mem_data = bus.mem_hold ? 32'hBAD0_BAD0 : mdata(bus.mem_addr);

  // Slow mode: two stall cycles precede every word of a fill.
  always @(posedge clock) begin
    #2;
    if (slow && !bus.mem_ce_n) begin
      if (st < 2) begin bus.mem_hold = 1'b1; st++; end
      else begin bus.mem_hold = 1'b0; st = 0; end
    end else begin
      bus.mem_hold = slow;
      st = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    slow  = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Holds an address until it hits; reports stall cycles, fill cycles, reads and stall stability.
  task automatic fetch(input logic [31:0] a, output int hc, output int fc, output int rd,
                       output logic [31:0] ins, output bit stable);
    logic [31:0] pa;
    bit          pst;
    pa = '0; pst = 1'b0;
    hc = 0; fc = 0; rd = 0; stable = 1'b1;
    i_address = a;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (!hold) break;
      hc++;
      if (!bus.mem_ce_n) begin
        fc++;
        if (!bus.mem_hold) rd++;
        if (pst && (bus.mem_addr !== pa)) stable = 1'b0;
        pst = bus.mem_hold;
        pa  = bus.mem_addr;
      end else begin
        pst = 1'b0;
      end
      @(posedge clock);
      #1;
    end
    chk("fetch_timeout_hold", {31'd0, hold}, 32'd0);
    ins = instruction;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        hold;
    logic [31:0] instr;
    logic [31:0] maddr;
    logic        ce_n;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hc, fc, rd;
    logic [31:0] ins;
    bit stable;

    vecs[0] = '{32'h0040_0000, 1'b1, 32'd0,               32'd0,        1'b1};
    vecs[1] = '{32'h0040_0000, 1'b1, 32'd0,               32'h0040_0000, 1'b0};
    vecs[2] = '{32'h0040_0000, 1'b1, 32'd0,               32'h0040_0004, 1'b0};
    vecs[3] = '{32'h0040_0000, 1'b1, 32'd0,               32'h0040_0008, 1'b0};
    vecs[4] = '{32'h0040_0000, 1'b1, 32'd0,               32'h0040_000C, 1'b0};
    vecs[5] = '{32'h0040_0000, 1'b0, mdata(32'h0040_0000), 32'd0,        1'b1};
    vecs[6] = '{32'h0040_0004, 1'b0, mdata(32'h0040_0004), 32'd0,        1'b1};
    vecs[7] = '{32'h0040_0008, 1'b0, mdata(32'h0040_0008), 32'd0,        1'b1};
    vecs[8] = '{32'h0040_000C, 1'b0, mdata(32'h0040_000C), 32'd0,        1'b1};

    reset = 1'b1; flush = 1'b0; i_address = 32'h0040_0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_hold", {31'd0, hold}, 32'd1);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_ce_n", {31'd0, bus.mem_ce_n}, 32'd1);
    chk("rst_oe_n", {31'd0, bus.mem_oe_n}, 32'd1);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Cold miss followed by spatial-locality hits.
    for (int i = 0; i < 9; i++) begin
      i_address = vecs[i].addr;
      @(negedge clock);
      chk($sformatf("vec%0d_hold", i), {31'd0, hold}, {31'd0, vecs[i].hold});
      chk($sformatf("vec%0d_instr", i), instruction, vecs[i].instr);
      chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vecs[i].maddr);
      chk($sformatf("vec%0d_ce_n", i), {31'd0, bus.mem_ce_n}, {31'd0, vecs[i].ce_n});
      @(posedge clock);
      #1;
    end
    chk("loc_hits", hit_count, 32'd4);
    chk("loc_misses", miss_count, 32'd1);

    // Conflict eviction on index 0.
    do_reset();
    fetch(32'h0040_0000, hc, fc, rd, ins, stable);
    chk("cf1_reads", rd, 32'd4);
    chk("cf1_hold_cycles", hc, 32'd5);
    chk("cf1_instr", ins, mdata(32'h0040_0000));
    fetch(32'h0040_0100, hc, fc, rd, ins, stable);
    chk("cf2_reads", rd, 32'd4);
    chk("cf2_instr", ins, mdata(32'h0040_0100));
    fetch(32'h0040_0000, hc, fc, rd, ins, stable);
    chk("cf3_reads", rd, 32'd4);
    chk("cf3_instr", ins, mdata(32'h0040_0000));
    chk("cf_misses", miss_count, 32'd3);

    // Slow memory: two stall cycles per word.
    do_reset();
    slow = 1'b1;
    fetch(32'h0040_0000, hc, fc, rd, ins, stable);
    chk("slow_fill_cycles", fc, 32'd12);
    chk("slow_hold_cycles", hc, 32'd13);
    chk("slow_reads", rd, 32'd4);
    chk("slow_addr_stable", {31'd0, stable}, 32'd1);
    chk("slow_w0", ins, mdata(32'h0040_0000));
    for (int w = 1; w < 4; w++) begin
      fetch(32'h0040_0000 + 32'(w * 4), hc, fc, rd, ins, stable);
      chk($sformatf("slow_w%0d_hold", w), hc, 32'd0);
      chk($sformatf("slow_w%0d", w), ins, mdata(32'h0040_0000 + 32'(w * 4)));
    end
    slow = 1'b0;

    // Flush at the second fill word.
    do_reset();
    i_address = 32'h0040_0000;
    @(posedge clock); #1;
    @(posedge clock); #1;
    flush = 1'b1;
    @(negedge clock);
    chk("fl_hold", {31'd0, hold}, 32'd1);
    chk("fl_instr", instruction, 32'd0);
    @(posedge clock);
    #1 flush = 1'b0;
    #1;
    chk("fl_run_ce_n", {31'd0, bus.mem_ce_n}, 32'd1);
    chk("fl_run_hold", {31'd0, hold}, 32'd1);
    fetch(32'h0040_0000, hc, fc, rd, ins, stable);
    chk("fl_refill_reads", rd, 32'd4);
    chk("fl_refill_instr", ins, mdata(32'h0040_0000));
    chk("fl_misses", miss_count, 32'd2);

    // Flush coinciding with the last-word capture leaves the line invalid.
    do_reset();
    i_address = 32'h0040_0000;
    repeat (4) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    fetch(32'h0040_0000, hc, fc, rd, ins, stable);
    chk("fll_hold_cycles", hc, 32'd5);
    chk("fll_reads", rd, 32'd4);
    chk("fll_misses", miss_count, 32'd2);

    // Reset at the second fill word.
    do_reset();
    i_address = 32'h0040_0000;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("rf_ce_n", {31'd0, bus.mem_ce_n}, 32'd1);
    chk("rf_mem_addr", bus.mem_addr, 32'd0);
    chk("rf_hold", {31'd0, hold}, 32'd1);
    chk("rf_misses", miss_count, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    fetch(32'h0040_0000, hc, fc, rd, ins, stable);
    chk("rf_hold_cycles", hc, 32'd5);
    chk("rf_reads", rd, 32'd4);
    chk("rf_instr", ins, mdata(32'h0040_0000));
    chk("rf_misses_after", miss_count, 32'd1);
    chk("rf_hits_after", hit_count, 32'd1);

    // Flush during a hit stalls the CPU and does not count as a hit.
    flush = 1'b1;
    #1;
    chk("fh_hold", {31'd0, hold}, 32'd1);
    chk("fh_instr", instruction, 32'd0);
    @(posedge clock);
    #1 flush = 1'b0;
    chk("fh_hits", hit_count, 32'd1);
    chk("fh_misses", miss_count, 32'd1);
    fetch(32'h0040_0000, hc, fc, rd, ins, stable);
    chk("fh_refill_reads", rd, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
